cadder_ctrl: RTL and testbench

Sequencer for the 26-bit accumulating adder (`cadder`) in the state-update datapath. It drives the adder's `en`/`in_sel` for two operations:
- N-term multiply-accumulate with an optional constant (bias) add.
- Single-cycle mixture-complement add.

It paces consumption of multiplier results through a valid/ready handshake, tracks a sticky overflow flag and pulses `done` when the adder's registered `sumout` holds the final result.

---
 rtl/cadder_ctrl.sv | 124 ++++++++++++
 tb/tb_cadder_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/cadder_ctrl.sv
// Sequencer for the 26-bit accumulating adder: drives en/in_sel for MAC (+ optional bias) and complement ops.
// Define CADDER_CTRL_BIAS_EN to append a one-cycle bias add (in_sel=10) to every MAC.
module cadder_ctrl #(
  parameter int NW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          op,
  input  logic [NW-1:0] n_terms,
  input  logic          abort,
  input  logic          mul_valid,
  output logic          mul_ready,
  input  logic          add_ovf,
  output logic          add_en,
  output logic [1:0]    add_sel,
  output logic          busy,
  output logic          done,
  output logic          ovf_sticky,
  output logic [NW-1:0] term_idx
);

`ifdef CADDER_CTRL_BIAS_EN
  typedef enum logic [2:0] {IDLE, FIRST, ACC, BIAS, CPL, DONE} state_t;
  localparam state_t MAC_END = BIAS;
`else
  typedef enum logic [2:0] {IDLE, FIRST, ACC, CPL, DONE} state_t;
  localparam state_t MAC_END = DONE;
`endif

  state_t        state_reg, state_next;
  logic [NW-1:0] n_reg;
  logic [NW-1:0] term_idx_reg;
  logic [NW-1:0] idx_inc;
  logic          ovf_reg;
  logic          en_d_reg;
  logic          busy_reg, busy_next;
  logic          done_reg;
  logic          accept;

  assign idx_inc = term_idx_reg + NW'(1);
  assign accept  = (state_reg == IDLE) && start && !abort;

  always_comb begin
    state_next = state_reg;
    add_en     = 1'b0;
    add_sel    = 2'b00;
    mul_ready  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = op ? CPL : FIRST;
      end
      FIRST: begin
        add_sel   = 2'b00;
        add_en    = mul_valid;
        mul_ready = mul_valid;
        if (mul_valid) state_next = (n_reg > NW'(1)) ? ACC : MAC_END;
      end
      ACC: begin
        add_sel   = 2'b01;
        add_en    = mul_valid;
        mul_ready = mul_valid;
        if (mul_valid && (idx_inc == n_reg)) state_next = MAC_END;
      end
`ifdef CADDER_CTRL_BIAS_EN
      BIAS: begin
        add_sel    = 2'b10;
        add_en     = 1'b1;
        state_next = DONE;
      end
`endif
      CPL: begin
        add_sel    = 2'b11;
        add_en     = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // Abort kills the enable in the same cycle so the adder never sees a partial step.
    if (abort) begin
      state_next = IDLE;
      add_en     = 1'b0;
      mul_ready  = 1'b0;
    end
    busy_next = (state_next != IDLE) && (state_next != DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      n_reg        <= '0;
      term_idx_reg <= '0;
      ovf_reg      <= 1'b0;
      en_d_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      en_d_reg  <= add_en;
      busy_reg  <= busy_next;
      done_reg  <= (state_next == DONE);
      if (accept) begin
        n_reg        <= (n_terms == '0) ? NW'(1) : n_terms;
        term_idx_reg <= '0;
        ovf_reg      <= 1'b0;
      end else begin
        if (mul_ready) term_idx_reg <= idx_inc;
        // Only overflow following one of our own enables counts; older flags are stale.
        if (en_d_reg) ovf_reg <= ovf_reg | add_ovf;
      end
    end
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign ovf_sticky = ovf_reg;
  assign term_idx   = term_idx_reg;

endmodule

// File: tb/tb_cadder_ctrl.sv
// Directed self-checking bench for cadder_ctrl; expectations adapt to CADDER_CTRL_BIAS_EN.
module tb_cadder_ctrl;
  logic       clk = 1'b0;
  logic       reset, start, op, abort, mul_valid, add_ovf;
  logic [5:0] n_terms;
  logic       mul_ready, add_en, busy, done, ovf_sticky;
  logic [1:0] add_sel;
  logic [5:0] term_idx;

  int n_cmp = 0;
  int n_err = 0;

`ifdef CADDER_CTRL_BIAS_EN
  localparam bit B = 1'b1;
`else
  localparam bit B = 1'b0;
`endif

  // {busy, done, mul_ready, add_en, add_sel}
  localparam logic [5:0] S_IDLE  = 6'b000000;
  localparam logic [5:0] S_FIRST = 6'b101100;
  localparam logic [5:0] S_ACC   = 6'b101101;
  localparam logic [5:0] S_ACCW  = 6'b100001;
  localparam logic [5:0] S_BIAS  = 6'b100110;
  localparam logic [5:0] S_CPL   = 6'b100111;
  localparam logic [5:0] S_DONE  = 6'b010000;

  cadder_ctrl #(.NW(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .n_terms(n_terms),
    .abort(abort), .mul_valid(mul_valid), .mul_ready(mul_ready), .add_ovf(add_ovf),
    .add_en(add_en), .add_sel(add_sel), .busy(busy), .done(done),
    .ovf_sticky(ovf_sticky), .term_idx(term_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // One cycle: drive inputs, check the decoded outputs mid-cycle, advance past the next edge.
  task automatic cyc(input string tag, input logic st, input logic o, input logic [5:0] n,
                     input logic v, input logic ab, input logic ov, input logic [5:0] e);
    start = st; op = o; n_terms = n; mul_valid = v; abort = ab; add_ovf = ov;
    #1;
    check(tag, {26'd0, busy, done, mul_ready, add_en, add_sel}, {26'd0, e});
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 1'b0; n_terms = '0;
    abort = 1'b0; mul_valid = 1'b0; add_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vec", {26'd0, busy, done, mul_ready, add_en, add_sel}, 32'd0);
    check("rst_ovf", {31'd0, ovf_sticky}, 32'd0);
    check("rst_idx", {26'd0, term_idx}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // MAC, N=4, products always valid
    cyc("t1_c0", 1, 0, 4, 1, 0, 0, S_IDLE);
    cyc("t1_c1", 0, 0, 4, 1, 0, 0, S_FIRST);
    cyc("t1_c2", 0, 0, 4, 1, 0, 0, S_ACC);
    cyc("t1_c3", 0, 0, 4, 1, 0, 0, S_ACC);
    cyc("t1_c4", 0, 0, 4, 1, 0, 0, S_ACC);
    cyc("t1_c5", 0, 0, 4, 1, 0, 0, B ? S_BIAS : S_DONE);
    cyc("t1_c6", 0, 0, 4, 1, 0, 0, B ? S_DONE : S_IDLE);
    check("t1_idx", {26'd0, term_idx}, 32'd4);

    // MAC, N=3, valid low in cycles 2-3
    cyc("t2_c0", 1, 0, 3, 1, 0, 0, S_IDLE);
    cyc("t2_c1", 0, 0, 3, 1, 0, 0, S_FIRST);
    cyc("t2_c2", 0, 0, 3, 0, 0, 0, S_ACCW);
    cyc("t2_c3", 0, 0, 3, 0, 0, 0, S_ACCW);
    cyc("t2_c4", 0, 0, 3, 1, 0, 0, S_ACC);
    cyc("t2_c5", 0, 0, 3, 1, 0, 0, S_ACC);
    cyc("t2_c6", 0, 0, 3, 1, 0, 0, B ? S_BIAS : S_DONE);
    cyc("t2_c7", 0, 0, 3, 1, 0, 0, B ? S_DONE : S_IDLE);
    check("t2_idx", {26'd0, term_idx}, 32'd3);

    // n_terms = 0 behaves as one term
    cyc("t3_c0", 1, 0, 0, 1, 0, 0, S_IDLE);
    cyc("t3_c1", 0, 0, 0, 1, 0, 0, S_FIRST);
    check("t3_idx", {26'd0, term_idx}, 32'd1);
    cyc("t3_c2", 0, 0, 0, 1, 0, 0, B ? S_BIAS : S_DONE);
    cyc("t3_c3", 0, 0, 0, 1, 0, 0, B ? S_DONE : S_IDLE);

    // Complement op; start in cycle 1 must be ignored
    cyc("t4_c0", 1, 1, 5, 1, 0, 0, S_IDLE);
    cyc("t4_c1", 1, 0, 5, 1, 0, 0, S_CPL);
    cyc("t4_c2", 0, 0, 5, 1, 0, 0, S_DONE);
    cyc("t4_c3", 0, 0, 5, 1, 0, 0, S_IDLE);
    cyc("t4_c4", 0, 0, 5, 1, 0, 0, S_IDLE);

    // Overflow after the 2nd enable (visible in cycle 3)
    cyc("t5a_c0", 1, 0, 4, 1, 0, 0, S_IDLE);
    cyc("t5a_c1", 0, 0, 4, 1, 0, 0, S_FIRST);
    cyc("t5a_c2", 0, 0, 4, 1, 0, 0, S_ACC);
    check("t5a_ovf_c3", {31'd0, ovf_sticky}, 32'd0);
    cyc("t5a_c3", 0, 0, 4, 1, 0, 1, S_ACC);
    check("t5a_ovf_c4", {31'd0, ovf_sticky}, 32'd1);
    cyc("t5a_c4", 0, 0, 4, 1, 0, 0, S_ACC);
    cyc("t5a_c5", 0, 0, 4, 1, 0, 0, B ? S_BIAS : S_DONE);
    check("t5a_ovf_c6", {31'd0, ovf_sticky}, 32'd1);
    cyc("t5a_c6", 0, 0, 4, 1, 0, 0, B ? S_DONE : S_IDLE);
    check("t5a_ovf_hold", {31'd0, ovf_sticky}, 32'd1);

    // Stale overflow around start must not set the new operation's flag
    cyc("t5b_c0", 1, 0, 2, 1, 0, 1, S_IDLE);
    cyc("t5b_c1", 0, 0, 2, 1, 0, 1, S_FIRST);
    check("t5b_ovf_c2", {31'd0, ovf_sticky}, 32'd0);
    cyc("t5b_c2", 0, 0, 2, 1, 0, 0, S_ACC);
    cyc("t5b_c3", 0, 0, 2, 1, 0, 0, B ? S_BIAS : S_DONE);
    cyc("t5b_c4", 0, 0, 2, 1, 0, 0, B ? S_DONE : S_IDLE);
    check("t5b_ovf_end", {31'd0, ovf_sticky}, 32'd0);

    // Abort in ACC; then abort+start together in IDLE
    cyc("t6_c0", 1, 0, 4, 1, 0, 0, S_IDLE);
    cyc("t6_c1", 0, 0, 4, 1, 0, 0, S_FIRST);
    cyc("t6_c2", 0, 0, 4, 1, 0, 0, S_ACC);
    cyc("t6_c3", 0, 0, 4, 1, 1, 0, S_ACCW);
    cyc("t6_c4", 0, 0, 4, 1, 0, 0, S_IDLE);
    cyc("t6_c5", 0, 0, 4, 1, 0, 0, S_IDLE);
    check("t6_idx", {26'd0, term_idx}, 32'd2);
    cyc("t6_c6", 1, 0, 4, 1, 1, 0, S_IDLE);
    cyc("t6_c7", 0, 0, 4, 1, 0, 0, S_IDLE);

    // Reset in ACC, with an overflow that would otherwise register
    cyc("t7_c0", 1, 0, 4, 1, 0, 0, S_IDLE);
    cyc("t7_c1", 0, 0, 4, 1, 0, 0, S_FIRST);
    reset = 1'b1;
    cyc("t7_c2", 0, 0, 4, 1, 0, 1, S_ACC);
    reset = 1'b0;
    check("t7_ovf", {31'd0, ovf_sticky}, 32'd0);
    check("t7_idx", {26'd0, term_idx}, 32'd0);
    cyc("t7_c3", 0, 0, 4, 1, 0, 0, S_IDLE);
    cyc("t7_c4", 0, 0, 4, 1, 0, 0, S_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
